// File: rtl/port_ingress_frame_buffer_pkg.sv
// Shared switch definitions for the per-port ingress frame buffer.
//   ingress_state_type      : frame assembly state of one ingress port
//   START_FLAG_BIT          : bit of a buffer word that marks the first byte of a frame
//   WORD_WIDTH              : width of a buffer word ({start flag, byte})
//   MIN_FRAME_BYTES_DEFAULT : shortest frame kept (destination + source MAC)
package port_ingress_frame_buffer_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RECEIVE = 2'd1,
        S_DISCARD = 2'd2
    } ingress_state_type;

    localparam int unsigned START_FLAG_BIT          = 8;
    localparam int unsigned WORD_WIDTH              = START_FLAG_BIT + 1;
    localparam int unsigned MIN_FRAME_BYTES_DEFAULT = 12;

endpackage

// File: rtl/port_ingress_buffer_memory.sv
// Frame buffer storage: DEPTH x WIDTH flop array.
//   clock, reset_n  : system clock, asynchronous active-low reset (clears array)
//   write_enable    : store write_data at write_address on the rising edge
//   write_address   : write location
//   write_data      : word to store
//   read_address    : asynchronous read location
//   read_data       : word at read_address
module port_ingress_buffer_memory #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 9,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] write_address,
    input  logic [WIDTH-1:0]  write_data,
    input  logic [ADDR_W-1:0] read_address,
    output logic [WIDTH-1:0]  read_data
);

    logic [WIDTH-1:0] storage [DEPTH];

    // Cleared on reset so the read port shows zero while the buffer is empty.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else if (write_enable) begin
            storage[write_address] <= write_data;
        end
    end

    assign read_data = storage[read_address];

endmodule

// File: rtl/port_ingress_frame_buffer.sv
// Per-port receive buffer between the RX MAC byte stream and the switch core.
// Frames are tagged (bit 8 on the first byte), written to a FIFO and made
// visible to the core only once committed. Runts and overflowing frames are
// rolled back and counted.
//   clock, reset_n            : system clock, asynchronous active-low reset
//   rx_data                   : received byte
//   rx_data_valid             : rx_data valid this cycle
//   rx_start_of_frame         : rx_data is the first byte of a new frame
//   port_recieve_data         : {start flag, byte} at the read pointer (FWFT)
//   port_recieve_data_enable  : a committed word is available
//   port_receive_data_ready   : consumer pops the current word
//   frame_drop_count          : saturating count of dropped frames
//   fill_level                : words written (committed or not) and not yet read
module port_ingress_frame_buffer
    import port_ingress_frame_buffer_pkg::*;
#(
    parameter int unsigned DEPTH              = 64,
    parameter int unsigned MIN_FRAME_BYTES    = MIN_FRAME_BYTES_DEFAULT,
    parameter logic [15:0] IDLE_COMMIT_CYCLES = 16'h0008
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [7:0]              rx_data,
    input  logic                    rx_data_valid,
    input  logic                    rx_start_of_frame,
    output logic [WORD_WIDTH-1:0]   port_recieve_data,
    output logic                    port_recieve_data_enable,
    input  logic                    port_receive_data_ready,
    output logic [15:0]             frame_drop_count,
    output logic [$clog2(DEPTH):0]  fill_level
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_DEPTH  = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] MIN_LENGTH = PTR_W'(MIN_FRAME_BYTES);

    ingress_state_type state, state_next;

    logic [PTR_W-1:0] wr_ptr, wr_ptr_next;
    logic [PTR_W-1:0] commit_ptr, commit_ptr_next;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] frame_length, frame_length_next;
    logic [15:0]      idle_count, idle_count_next, idle_count_inc;
    logic [15:0]      drop_count;

    logic             start_byte;
    logic             idle_tick;
    logic             close_frame;
    logic             open_frame;
    logic             append_byte;
    logic             overflow;
    logic             commit_ok;
    logic             open_room;
    logic             drop_inc;
    logic             pop;
    logic [PTR_W-1:0] used;
    logic [PTR_W-1:0] open_base;
    logic [PTR_W-1:0] open_used;

    logic                  mem_write_enable;
    logic [ADDR_W-1:0]     mem_write_address;
    logic [WORD_WIDTH-1:0] mem_write_data;

    assign start_byte     = rx_data_valid && rx_start_of_frame;
    assign idle_count_inc = idle_count + 16'd1;
    assign used           = wr_ptr - rd_ptr;
    assign commit_ok      = (frame_length >= MIN_LENGTH);
    assign mem_write_data = {rx_start_of_frame, rx_data};

    // A new frame started while one is open begins where the open frame ends
    // after it is resolved: at wr_ptr if committed, at commit_ptr if rolled back.
    // Rollback always frees space, so a runt drop and a blocked start never
    // coincide and the drop count steps by at most one per cycle.
    assign open_base = (close_frame && !commit_ok) ? commit_ptr : wr_ptr;
    assign open_used = open_base - rd_ptr;
    assign open_room = (open_used != PTR_DEPTH);

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and per-cycle frame decisions
    always_comb begin
        state_next  = state;
        close_frame = 1'b0;
        open_frame  = 1'b0;
        append_byte = 1'b0;
        overflow    = 1'b0;
        idle_tick   = 1'b0;
        case (state)
            S_IDLE, S_DISCARD: begin
                if (start_byte) begin
                    open_frame = 1'b1;
                end
            end
            S_RECEIVE: begin
                if (start_byte) begin
                    close_frame = 1'b1;
                    open_frame  = 1'b1;
                end else if (rx_data_valid) begin
                    if (used == PTR_DEPTH) begin
                        overflow = 1'b1;
                    end else begin
                        append_byte = 1'b1;
                    end
                end else begin
                    idle_tick = 1'b1;
                    if (idle_count_inc == IDLE_COMMIT_CYCLES) begin
                        close_frame = 1'b1;
                        state_next  = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (overflow || (open_frame && !open_room)) begin
            state_next = S_DISCARD;
        end else if (open_frame) begin
            state_next = S_RECEIVE;
        end
    end

    // Datapath control: pointer updates, buffer writes, counters
    always_comb begin
        wr_ptr_next       = wr_ptr;
        commit_ptr_next   = commit_ptr;
        frame_length_next = frame_length;
        idle_count_next   = idle_count;
        drop_inc          = 1'b0;
        mem_write_enable  = 1'b0;
        mem_write_address = wr_ptr[ADDR_W-1:0];

        if (close_frame) begin
            if (commit_ok) begin
                commit_ptr_next = wr_ptr;
            end else begin
                wr_ptr_next = commit_ptr;
                drop_inc    = 1'b1;
            end
            frame_length_next = '0;
            idle_count_next   = '0;
        end

        if (overflow) begin
            wr_ptr_next       = commit_ptr;
            drop_inc          = 1'b1;
            frame_length_next = '0;
            idle_count_next   = '0;
        end

        if (append_byte) begin
            mem_write_enable  = 1'b1;
            wr_ptr_next       = wr_ptr + PTR_ONE;
            frame_length_next = frame_length + PTR_ONE;
            idle_count_next   = '0;
        end

        if (idle_tick && !close_frame) begin
            idle_count_next = idle_count_inc;
        end

        if (open_frame) begin
            if (open_room) begin
                mem_write_enable  = 1'b1;
                mem_write_address = open_base[ADDR_W-1:0];
                wr_ptr_next       = open_base + PTR_ONE;
                frame_length_next = PTR_ONE;
                idle_count_next   = '0;
            end else begin
                drop_inc = 1'b1;
            end
        end
    end

    assign port_recieve_data_enable = (rd_ptr != commit_ptr);
    assign pop                      = port_recieve_data_enable && port_receive_data_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            commit_ptr   <= '0;
            rd_ptr       <= '0;
            frame_length <= '0;
            idle_count   <= '0;
            drop_count   <= '0;
        end else begin
            wr_ptr       <= wr_ptr_next;
            commit_ptr   <= commit_ptr_next;
            frame_length <= frame_length_next;
            idle_count   <= idle_count_next;
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (drop_inc && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    assign frame_drop_count = drop_count;
    assign fill_level       = used;

    port_ingress_buffer_memory #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_WIDTH)
    ) buffer_memory (
        .clock         (clock),
        .reset_n       (reset_n),
        .write_enable  (mem_write_enable),
        .write_address (mem_write_address),
        .write_data    (mem_write_data),
        .read_address  (rd_ptr[ADDR_W-1:0]),
        .read_data     (port_recieve_data)
    );

endmodule

// File: tb/tb_port_ingress_frame_buffer.sv
// Self-checking bench for port_ingress_frame_buffer (DEPTH = 16).
// The reference model holds the committed words and the open frame as queues
// and applies the frame rules directly.
module tb_port_ingress_frame_buffer;

    localparam int unsigned DEPTH      = 16;
    localparam int unsigned MIN_BYTES  = 12;
    localparam int unsigned IDLE_LIMIT = 8;
    localparam int unsigned FILL_W     = $clog2(DEPTH) + 1;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [7:0]        rx_data;
    logic              rx_data_valid;
    logic              rx_start_of_frame;
    logic [8:0]        port_recieve_data;
    logic              port_recieve_data_enable;
    logic              port_receive_data_ready;
    logic [15:0]       frame_drop_count;
    logic [FILL_W-1:0] fill_level;

    int checks_total  = 0;
    int checks_passed = 0;

    // reference model state
    logic [8:0] cq[$];   // committed, unread words
    logic [8:0] oq[$];   // words of the open frame
    bit         m_open;
    int         m_idle;
    int         m_drop;

    always #5 clock = ~clock;

    port_ingress_frame_buffer #(
        .DEPTH              (DEPTH),
        .MIN_FRAME_BYTES    (MIN_BYTES),
        .IDLE_COMMIT_CYCLES (16'(IDLE_LIMIT))
    ) dut (
        .clock                    (clock),
        .reset_n                  (reset_n),
        .rx_data                  (rx_data),
        .rx_data_valid            (rx_data_valid),
        .rx_start_of_frame        (rx_start_of_frame),
        .port_recieve_data        (port_recieve_data),
        .port_recieve_data_enable (port_recieve_data_enable),
        .port_receive_data_ready  (port_receive_data_ready),
        .frame_drop_count         (frame_drop_count),
        .fill_level               (fill_level)
    );

    task automatic model_reset();
        cq.delete();
        oq.delete();
        m_open = 1'b0;
        m_idle = 0;
        m_drop = 0;
    endtask

    task automatic model_drop();
        if (m_drop < 65535) m_drop++;
    endtask

    task automatic model_close();
        if (oq.size() >= MIN_BYTES) begin
            foreach (oq[k]) cq.push_back(oq[k]);
        end else begin
            model_drop();
        end
        oq.delete();
        m_open = 1'b0;
        m_idle = 0;
    endtask

    task automatic model_edge(bit v, bit s, logic [7:0] d, bit r);
        bit pop;
        pop = r && (cq.size() != 0);
        if (v && s) begin
            if (m_open) model_close();
            if (cq.size() + oq.size() < DEPTH) begin
                oq.push_back({1'b1, d});
                m_open = 1'b1;
                m_idle = 0;
            end else begin
                model_drop();
            end
        end else if (m_open) begin
            if (v) begin
                if (cq.size() + oq.size() == DEPTH) begin
                    oq.delete();
                    m_open = 1'b0;
                    model_drop();
                end else begin
                    oq.push_back({1'b0, d});
                    m_idle = 0;
                end
            end else begin
                m_idle++;
                if (m_idle == IDLE_LIMIT) model_close();
            end
        end
        if (pop) void'(cq.pop_front());
    endtask

    // drive one cycle of inputs; outputs are sampled 1 time unit after the edge
    task automatic step(bit v, bit s, logic [7:0] d, bit r);
        @(negedge clock);
        rx_data_valid           = v;
        rx_start_of_frame       = s;
        rx_data                 = d;
        port_receive_data_ready = r;
        @(posedge clock);
        if (reset_n) model_edge(v, s, d, r);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rx_data_valid = 1'b0; rx_start_of_frame = 1'b0; rx_data = 8'h00;
        port_receive_data_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        checks_total++;
        if (port_recieve_data !== 9'h000) $display("FAIL reset_data: got %h want 000", port_recieve_data); else checks_passed++;
        checks_total++;
        if (port_recieve_data_enable !== 1'b0) $display("FAIL reset_enable: got %b want 0", port_recieve_data_enable); else checks_passed++;
        checks_total++;
        if (frame_drop_count !== 16'h0000) $display("FAIL reset_drop: got %h want 0000", frame_drop_count); else checks_passed++;
        checks_total++;
        if (fill_level !== '0) $display("FAIL reset_fill: got %0d want 0", fill_level); else checks_passed++;
        reset_n = 1'b1;
    endtask

    task automatic test_basic_frame();
        logic [8:0] seen[$];
        logic [8:0] want;
        for (int i = 0; i < 14; i++) begin
            step(1'b1, i == 0, 8'(i), 1'b1);
            checks_total++;
            if (port_recieve_data_enable !== 1'b0) $display("FAIL basic_early_enable byte %0d: got %b want 0", i, port_recieve_data_enable); else checks_passed++;
        end
        for (int j = 0; j < 26; j++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            checks_total++;
            if (port_recieve_data_enable !== (cq.size() != 0)) $display("FAIL basic_enable idle %0d: got %b want %b", j, port_recieve_data_enable, cq.size() != 0); else checks_passed++;
            if (j == 6) begin
                checks_total++;
                if (port_recieve_data_enable !== 1'b0) $display("FAIL basic_before_commit: got %b want 0", port_recieve_data_enable); else checks_passed++;
            end
            if (j == 7) begin
                checks_total++;
                if (port_recieve_data_enable !== 1'b1) $display("FAIL basic_after_commit: got %b want 1", port_recieve_data_enable); else checks_passed++;
            end
            if (port_recieve_data_enable === 1'b1) seen.push_back(port_recieve_data);
        end
        checks_total++;
        if (seen.size() != 14) $display("FAIL basic_word_count: got %0d want 14", seen.size()); else checks_passed++;
        for (int k = 0; k < 14 && k < seen.size(); k++) begin
            want = (k == 0) ? 9'h100 : 9'(k);
            checks_total++;
            if (seen[k] !== want) $display("FAIL basic_word %0d: got %h want %h", k, seen[k], want); else checks_passed++;
        end
        checks_total++;
        if (fill_level !== '0) $display("FAIL basic_fill_end: got %0d want 0", fill_level); else checks_passed++;
    endtask

    task automatic test_runt();
        int drop_before;
        drop_before = m_drop;
        for (int i = 0; i < 5; i++) step(1'b1, i == 0, 8'h50 + 8'(i), 1'b1);
        for (int j = 0; j < 12; j++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            checks_total++;
            if (port_recieve_data_enable !== 1'b0) $display("FAIL runt_enable idle %0d: got %b want 0", j, port_recieve_data_enable); else checks_passed++;
        end
        checks_total++;
        if (frame_drop_count !== 16'(drop_before + 1)) $display("FAIL runt_drop: got %0d want %0d", frame_drop_count, drop_before + 1); else checks_passed++;
        checks_total++;
        if (fill_level !== '0) $display("FAIL runt_fill: got %0d want 0", fill_level); else checks_passed++;
    endtask

    task automatic test_overflow();
        int drop_before;
        drop_before = m_drop;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, i == 0, 8'h20 + 8'(i), 1'b0);
            if (i == 15) begin
                checks_total++;
                if (fill_level !== 5'd16) $display("FAIL ovf_full: got %0d want 16", fill_level); else checks_passed++;
            end
            if (i == 16) begin
                checks_total++;
                if (fill_level !== '0) $display("FAIL ovf_rollback_fill: got %0d want 0", fill_level); else checks_passed++;
                checks_total++;
                if (frame_drop_count !== 16'(drop_before + 1)) $display("FAIL ovf_drop: got %0d want %0d", frame_drop_count, drop_before + 1); else checks_passed++;
            end
        end
        checks_total++;
        if (fill_level !== '0) $display("FAIL ovf_discard_fill: got %0d want 0", fill_level); else checks_passed++;
        for (int i = 0; i < 12; i++) step(1'b1, i == 0, 8'h60 + 8'(i), 1'b0);
        for (int j = 0; j < IDLE_LIMIT; j++) step(1'b0, 1'b0, 8'h00, 1'b0);
        checks_total++;
        if (port_recieve_data_enable !== 1'b1) $display("FAIL ovf_next_enable: got %b want 1", port_recieve_data_enable); else checks_passed++;
        checks_total++;
        if (fill_level !== 5'd12) $display("FAIL ovf_next_fill: got %0d want 12", fill_level); else checks_passed++;
        for (int j = 0; j < 14; j++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            if (cq.size() != 0) begin
                checks_total++;
                if (port_recieve_data !== cq[0]) $display("FAIL ovf_drain_data %0d: got %h want %h", j, port_recieve_data, cq[0]); else checks_passed++;
            end
        end
        checks_total++;
        if (fill_level !== '0) $display("FAIL ovf_drain_fill: got %0d want 0", fill_level); else checks_passed++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) step(1'b1, i == 0, 8'hA0 + 8'(i), 1'b1);
        checks_total++;
        if (port_recieve_data_enable !== 1'b0) $display("FAIL b2b_before_b: got %b want 0", port_recieve_data_enable); else checks_passed++;
        step(1'b1, 1'b1, 8'hB0, 1'b1);
        checks_total++;
        if (port_recieve_data_enable !== 1'b1) $display("FAIL b2b_a_visible: got %b want 1", port_recieve_data_enable); else checks_passed++;
        checks_total++;
        if (port_recieve_data !== 9'h1A0) $display("FAIL b2b_a_first: got %h want 1a0", port_recieve_data); else checks_passed++;
        for (int i = 1; i < 12; i++) begin
            step(1'b1, 1'b0, 8'hB0 + 8'(i), 1'b1);
            checks_total++;
            if (port_recieve_data_enable !== (cq.size() != 0)) $display("FAIL b2b_enable byte %0d: got %b want %b", i, port_recieve_data_enable, cq.size() != 0); else checks_passed++;
            if (cq.size() != 0) begin
                checks_total++;
                if (port_recieve_data !== cq[0]) $display("FAIL b2b_data byte %0d: got %h want %h", i, port_recieve_data, cq[0]); else checks_passed++;
            end
        end
        for (int j = 0; j < IDLE_LIMIT; j++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            if (j == IDLE_LIMIT - 2) begin
                checks_total++;
                if (port_recieve_data_enable !== 1'b0) $display("FAIL b2b_b_held: got %b want 0", port_recieve_data_enable); else checks_passed++;
            end
        end
        checks_total++;
        if (port_recieve_data !== 9'h1B0) $display("FAIL b2b_b_first: got %h want 1b0", port_recieve_data); else checks_passed++;
        for (int j = 0; j < 14; j++) step(1'b0, 1'b0, 8'h00, 1'b1);
        checks_total++;
        if (fill_level !== '0) $display("FAIL b2b_fill_end: got %0d want 0", fill_level); else checks_passed++;
    endtask

    task automatic test_hold();
        for (int i = 0; i < 12; i++) step(1'b1, i == 0, 8'hC0 + 8'(i), 1'b0);
        for (int j = 0; j < IDLE_LIMIT; j++) step(1'b0, 1'b0, 8'h00, 1'b0);
        for (int j = 0; j < 10; j++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0);
            checks_total++;
            if (port_recieve_data !== 9'h1C0 || port_recieve_data_enable !== 1'b1) $display("FAIL hold_stable %0d: got %b/%h want 1/1c0", j, port_recieve_data_enable, port_recieve_data); else checks_passed++;
        end
        checks_total++;
        if (fill_level !== 5'd12) $display("FAIL hold_fill: got %0d want 12", fill_level); else checks_passed++;
        step(1'b0, 1'b0, 8'h00, 1'b1);
        for (int j = 0; j < 3; j++) begin
            checks_total++;
            if (port_recieve_data !== 9'h0C1) $display("FAIL hold_one_pop %0d: got %h want 0c1", j, port_recieve_data); else checks_passed++;
            checks_total++;
            if (fill_level !== 5'd11) $display("FAIL hold_one_fill %0d: got %0d want 11", j, fill_level); else checks_passed++;
            step(1'b0, 1'b0, 8'h00, 1'b0);
        end
        for (int j = 0; j < 12; j++) step(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 6; i++) step(1'b1, i == 0, 8'hD0 + 8'(i), 1'b1);
        reset_n = 1'b0;
        #1;
        checks_total++;
        if (port_recieve_data !== 9'h000 || port_recieve_data_enable !== 1'b0) $display("FAIL midreset_out: got %b/%h want 0/000", port_recieve_data_enable, port_recieve_data); else checks_passed++;
        checks_total++;
        if (frame_drop_count !== 16'h0000) $display("FAIL midreset_drop: got %0d want 0", frame_drop_count); else checks_passed++;
        checks_total++;
        if (fill_level !== '0) $display("FAIL midreset_fill: got %0d want 0", fill_level); else checks_passed++;
        model_reset();
        @(negedge clock);
        rx_data_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) step(1'b1, i == 0, 8'hE0 + 8'(i), 1'b0);
        for (int j = 0; j < IDLE_LIMIT; j++) step(1'b0, 1'b0, 8'h00, 1'b0);
        checks_total++;
        if (port_recieve_data_enable !== 1'b1 || port_recieve_data !== 9'h1E0) $display("FAIL midreset_frame: got %b/%h want 1/1e0", port_recieve_data_enable, port_recieve_data); else checks_passed++;
        checks_total++;
        if (fill_level !== 5'd12) $display("FAIL midreset_frame_fill: got %0d want 12", fill_level); else checks_passed++;
        for (int j = 0; j < 13; j++) step(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_random();
        int valid_pct;
        bit v, s, r;
        valid_pct = 90;
        for (int c = 0; c < 1500; c++) begin
            if (c % 40 == 0) valid_pct = ($urandom_range(0, 1) == 1) ? 95 : 25;
            v = ($urandom_range(0, 99) < valid_pct);
            s = ($urandom_range(0, 13) == 0);
            r = ($urandom_range(0, 99) < 45);
            step(v, s, 8'($urandom), r);
            checks_total++;
            if (port_recieve_data_enable !== (cq.size() != 0)) $display("FAIL rand_enable cycle %0d: got %b want %b", c, port_recieve_data_enable, cq.size() != 0); else checks_passed++;
            checks_total++;
            if (fill_level !== FILL_W'(cq.size() + oq.size())) $display("FAIL rand_fill cycle %0d: got %0d want %0d", c, fill_level, cq.size() + oq.size()); else checks_passed++;
            checks_total++;
            if (frame_drop_count !== 16'(m_drop)) $display("FAIL rand_drop cycle %0d: got %0d want %0d", c, frame_drop_count, m_drop); else checks_passed++;
            if (cq.size() != 0) begin
                checks_total++;
                if (port_recieve_data !== cq[0]) $display("FAIL rand_data cycle %0d: got %h want %h", c, port_recieve_data, cq[0]); else checks_passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_runt();
        test_overflow();
        test_back_to_back();
        test_hold();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/port_ingress_frame_buffer.md
Name: port_ingress_frame_buffer

Overview:
Per-port receive buffer between an RX MAC byte stream and the switch core data orchestrator, one instance per port.
- Tags the first byte of every frame with bit 8 and stores frames in a FIFO.
- Shows only whole, committed frames to the core, as first-word-fall-through words with an enable/ready handshake.
- Drops runt frames and frames that overflow the buffer without corrupting earlier frames, and counts the drops.

Parameters:
DEPTH, 64, number of 9-bit buffer words; power of two, at least MIN_FRAME_BYTES.
MIN_FRAME_BYTES, 12, frames shorter than this are discarded at commit (12 = destination + source MAC).
IDLE_COMMIT_CYCLES, 16'h0008, consecutive cycles with no RX byte after which an open frame is committed.

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
rx_data  input  8  received byte
rx_data_valid  input  1  rx_data valid this cycle
rx_start_of_frame  input  1  qualifies rx_data as first byte of a new frame (only meaningful when rx_data_valid)
port_recieve_data  output  9  {start flag, byte}; word at read pointer
port_recieve_data_enable  output  1  a committed word is available
port_receive_data_ready  input  1  consumer pops current word
frame_drop_count  output  16  saturating count of dropped frames
fill_level  output  $clog2(DEPTH)+1  words written, committed or not, and not yet read

Behaviour:
- Pointers are $clog2(DEPTH)+1 bits and wrap naturally: wr_ptr, commit_ptr, rd_ptr. Used = wr_ptr - rd_ptr; full when used == DEPTH.
- Stored word = {rx_start_of_frame, rx_data}. Storage is read asynchronously at rd_ptr.
- Read side:
  - port_recieve_data_enable = (rd_ptr != commit_ptr); port_recieve_data = mem[rd_ptr].
  - Pop when enable && ready. ready without enable is ignored.
  - Data and enable stay stable while ready is low; the consumer may inspect bit 8 without popping.
- States:
  - S_IDLE: no frame open. Valid bytes without start are ignored. A start byte opens a frame: write it, frame_length=1, go to S_RECEIVE.
  - S_RECEIVE:
    - A valid non-start byte is written; frame_length++; idle counter cleared.
    - A cycle with no valid byte increments the idle counter. When it reaches IDLE_COMMIT_CYCLES, commit and go to S_IDLE.
    - A valid start byte commits the current frame, then opens the new frame in the same cycle. The new frame's base is the post-commit (or post-rollback) wr_ptr.
  - S_DISCARD: all bytes ignored until a valid start byte, which opens a new frame exactly as from S_IDLE.
- Commit: if frame_length >= MIN_FRAME_BYTES, set commit_ptr <= wr_ptr (visible one cycle later). Otherwise roll back (wr_ptr <= commit_ptr) and increment the drop count.
- Overflow: a byte that arrives when full, including a start byte, is not written. The frame rolls back, the drop count increments and the state goes to S_DISCARD. Earlier committed words are untouched.
- Simultaneous write and pop in the same cycle are both honoured; space freed by a pop counts only from the next cycle.
- frame_drop_count saturates at 16'hFFFF.
- Reset: all pointers 0, state S_IDLE, counters 0. Outputs reset to port_recieve_data=0, enable=0, frame_drop_count=0, fill_level=0. Reset mid-frame discards everything.

Decomposition:
- Shared switch package holds:
  - ingress_state_type (S_IDLE, S_RECEIVE, S_DISCARD);
  - the start-flag bit index constant (8);
  - the MIN_FRAME_BYTES default.
- Natural sub-module: port_ingress_buffer_memory, DEPTH x 9 flop array with one synchronous write port and one asynchronous read port.
- A frame_length counter and an idle counter stay in the top-level block.

Test Plan:
- Ready held 1. 14-byte frame 0x00..0x0D with start on byte 0, then 8 idle cycles -> enable rises 1 cycle after commit. Outputs 0x100, 0x001..0x00D. fill_level returns to 0.
- 5-byte frame then idle -> enable never asserts, frame_drop_count=1, fill_level=0.
- DEPTH=16, ready=0, 20-byte frame -> rollback at byte 17, drop=1, fill_level=0. Next 12-byte frame is accepted and committed.
- 12-byte frame A, then frame B's start byte on the next cycle -> A is visible the cycle after B's start; B is held until its own commit.
- Enable=1 with ready=0 for 10 cycles -> port_recieve_data holds 0x1xx and rd_ptr does not move. One ready pulse pops exactly one word.
- reset_n low mid-frame with 6 bytes written -> outputs 0 immediately; after release, a fresh 12-byte frame commits normally.
